// File: rtl/ctrl_fsm_pkg.sv
// ctrl_fsm shared definitions: states, opcodes, select encodings.
// CTRL_ILLEGAL_TRAP_EN adds the TRAP state.
package ctrl_fsm_pkg;

    localparam int MXLEN = 32;

    // Sign-extender format select
    localparam logic [1:0] EXTNR_R = 2'd0;
    localparam logic [1:0] EXTNR_I = 2'd1;
    localparam logic [1:0] EXTNR_S = 2'd2;
    localparam logic [1:0] EXTNR_B = 2'd3;

    // Write-back source select
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // Next-PC source select
    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    // Opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        CTRL_S_FETCH  = 3'd0,
        CTRL_S_DECODE = 3'd1,
        CTRL_S_EXEC   = 3'd2,
        CTRL_S_MEM    = 3'd3,
        CTRL_S_WB     = 3'd4
`ifdef CTRL_ILLEGAL_TRAP_EN
        , CTRL_S_TRAP = 3'd5
`endif
    } ctrl_state_e;

    typedef enum logic [2:0] {
        OPK_OP     = 3'd0,
        OPK_OP_IMM = 3'd1,
        OPK_LOAD   = 3'd2,
        OPK_STORE  = 3'd3,
        OPK_BRANCH = 3'd4,
        OPK_JALR   = 3'd5,
        OPK_ILL    = 3'd6
    } opk_e;

endpackage

// File: rtl/ctrl_fsm_dec.sv
// ctrl_fsm opcode decoder: instruction kind, legality,
// extender format and ALU operand-B select.
module ctrl_fsm_dec
    import ctrl_fsm_pkg::*;
(
    input  logic [6:0] opcode,
    output opk_e       opk,
    output logic       legal,
    output logic [1:0] extnr_ops,
    output logic       alu_src_imm
);

    // Map opcode to kind; extender format and operand select follow
    always_comb begin
        opk         = OPK_ILL;
        extnr_ops   = EXTNR_R;
        alu_src_imm = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                opk = OPK_OP;
            end
            OPC_OP_IMM: begin
                opk         = OPK_OP_IMM;
                extnr_ops   = EXTNR_I;
                alu_src_imm = 1'b1;
            end
            OPC_LOAD: begin
                opk         = OPK_LOAD;
                extnr_ops   = EXTNR_I;
                alu_src_imm = 1'b1;
            end
            OPC_JALR: begin
                opk         = OPK_JALR;
                extnr_ops   = EXTNR_I;
                alu_src_imm = 1'b1;
            end
            OPC_STORE: begin
                opk         = OPK_STORE;
                extnr_ops   = EXTNR_S;
                alu_src_imm = 1'b1;
            end
            OPC_BRANCH: begin
                opk       = OPK_BRANCH;
                extnr_ops = EXTNR_B;
            end
            default: begin
                opk = OPK_ILL;
            end
        endcase
        legal = (opk != OPK_ILL);
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle RV32 control sequencer (FETCH/DECODE/EXEC/MEM/WB).
// CTRL_ILLEGAL_TRAP_EN: illegal opcodes enter a sticky TRAP state.
module ctrl_fsm
    import ctrl_fsm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic [MXLEN-1:0] imem_rdata,
    output logic [MXLEN-1:0] ir,
    output logic [1:0]       extnr_ops,
    input  logic             br_taken,
    output logic             alu_src_imm,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             retire
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic             trap
`endif
);

    ctrl_state_e      state_q, state_d;
    logic [MXLEN-1:0] ir_q, ir_d;
    logic             imem_req_q, imem_req_d;
    logic             dmem_req_q, dmem_req_d;
    logic             dmem_we_q, dmem_we_d;
    logic             rf_we_q, rf_we_d;
    logic [1:0]       wb_sel_q, wb_sel_d;
    logic             trap_q, trap_d;
    opk_e             opk;
    logic             legal;

    ctrl_fsm_dec u_dec (
        .opcode      (ir_q[6:0]),
        .opk         (opk),
        .legal       (legal),
        .extnr_ops   (extnr_ops),
        .alu_src_imm (alu_src_imm)
    );

    // Next state plus the PC/retire strobes, which depend on
    // same-cycle inputs (br_taken, dmem_ready)
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        trap_d  = trap_q;
        pc_we   = 1'b0;
        pc_sel  = PC_PLUS4;
        retire  = 1'b0;
        unique case (state_q)
            CTRL_S_FETCH: begin
                if (imem_req_q && imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = CTRL_S_DECODE;
                end
            end
            CTRL_S_DECODE: begin
                if (legal) begin
                    state_d = CTRL_S_EXEC;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    trap_d  = 1'b1;
                    state_d = CTRL_S_TRAP;
`else
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = CTRL_S_FETCH;
`endif
                end
            end
            CTRL_S_EXEC: begin
                if (opk == OPK_BRANCH) begin
                    pc_we   = 1'b1;
                    pc_sel  = br_taken ? PC_IMM : PC_PLUS4;
                    retire  = 1'b1;
                    state_d = CTRL_S_FETCH;
                end else if (opk == OPK_LOAD || opk == OPK_STORE) begin
                    state_d = CTRL_S_MEM;
                end else begin
                    state_d = CTRL_S_WB;
                end
            end
            CTRL_S_MEM: begin
                if (dmem_req_q && dmem_ready) begin
                    if (opk == OPK_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = CTRL_S_FETCH;
                    end else begin
                        state_d = CTRL_S_WB;
                    end
                end
            end
            CTRL_S_WB: begin
                pc_we   = 1'b1;
                pc_sel  = (opk == OPK_JALR) ? PC_ALU : PC_PLUS4;
                retire  = 1'b1;
                state_d = CTRL_S_FETCH;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            CTRL_S_TRAP: begin
                state_d = CTRL_S_TRAP;
            end
`endif
            default: begin
                state_d = CTRL_S_FETCH;
            end
        endcase
    end

    // Request/enable outputs are registered from the next state
    always_comb begin
        imem_req_d = (state_d == CTRL_S_FETCH);
        dmem_req_d = (state_d == CTRL_S_MEM);
        dmem_we_d  = (state_d == CTRL_S_MEM) && (opk == OPK_STORE);
        rf_we_d    = (state_d == CTRL_S_WB);
        wb_sel_d   = WB_ALU;
        if (state_d == CTRL_S_WB) begin
            if (opk == OPK_LOAD) begin
                wb_sel_d = WB_MEM;
            end else if (opk == OPK_JALR) begin
                wb_sel_d = WB_PC4;
            end
        end
    end

    // State, instruction register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CTRL_S_FETCH;
            ir_q       <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            wb_sel_q   <= WB_ALU;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            rf_we_q    <= rf_we_d;
            wb_sel_q   <= wb_sel_d;
            trap_q     <= trap_d;
        end
    end

    assign ir       = ir_q;
    assign imem_req = imem_req_q;
    assign dmem_req = dmem_req_q;
    assign dmem_we  = dmem_we_q;
    assign rf_we    = rf_we_q;
    assign wb_sel   = wb_sel_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign trap     = trap_q;
`else
    logic unused_trap;
    assign unused_trap = trap_q;
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed-vector bench for ctrl_fsm.
// Build with CTRL_ILLEGAL_TRAP_EN to exercise the TRAP path.
module tb_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [1:0]  extnr_ops;
    logic        br_taken;
    logic        alu_src_imm;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        retire;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic        trap;
`endif

    int n_vec = 0;
    int n_bad = 0;

    ctrl_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .extnr_ops   (extnr_ops),
        .br_taken    (br_taken),
        .alu_src_imm (alu_src_imm),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ready  (dmem_ready),
        .rf_we       (rf_we),
        .wb_sel      (wb_sel),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .retire      (retire)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .trap        (trap)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Complete a zero-wait fetch; lands in DECODE
    task automatic fetch(input logic [31:0] word);
        imem_rdata = word;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = '0;
        br_taken   = 1'b0;
        dmem_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst imem_req", imem_req, 0);
        chk("rst dmem_req", dmem_req, 0);
        chk("rst rf_we", rf_we, 0);
        chk("rst pc_we", pc_we, 0);
        chk("rst retire", retire, 0);
        chk("rst extnr", extnr_ops, 0);
        chk("rst ir", ir, 0);
        chk("rst alu_src", alu_src_imm, 0);
        rst = 1'b0;
        tick();
        chk("rel imem_req", imem_req, 1);

        // addi x1,x0,5
        fetch(32'h0050_0093);
        chk("addi c2 ir", ir, 32'h0050_0093);
        chk("addi c2 extnr", extnr_ops, 1);
        chk("addi c2 alusrc", alu_src_imm, 1);
        chk("addi c2 imem_req", imem_req, 0);
        chk("addi c2 retire", retire, 0);
        tick();
        chk("addi c3 retire", retire, 0);
        chk("addi c3 rf_we", rf_we, 0);
        chk("addi c3 extnr", extnr_ops, 1);
        tick();
        chk("addi c4 rf_we", rf_we, 1);
        chk("addi c4 wb_sel", wb_sel, 0);
        chk("addi c4 pc_we", pc_we, 1);
        chk("addi c4 pc_sel", pc_sel, 0);
        chk("addi c4 retire", retire, 1);
        tick();
        chk("addi c5 retire", retire, 0);
        chk("addi c5 rf_we", rf_we, 0);
        chk("addi c5 imem_req", imem_req, 1);

        // sw x2,8(x1), dmem_ready after 3 wait cycles
        fetch(32'h0020_A423);
        chk("sw extnr", extnr_ops, 2);
        chk("sw alusrc", alu_src_imm, 1);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("sw dmem_req", dmem_req, 1);
            chk("sw dmem_we", dmem_we, 1);
            chk("sw rf_we", rf_we, 0);
            if (i == 3) begin
                dmem_ready = 1'b1;
                #1;
                chk("sw retire", retire, 1);
                chk("sw pc_we", pc_we, 1);
                chk("sw pc_sel", pc_sel, 0);
            end else begin
                chk("sw wait retire", retire, 0);
            end
            tick();
        end
        dmem_ready = 1'b0;
        chk("sw post dmem_req", dmem_req, 0);
        chk("sw post rf_we", rf_we, 0);
        chk("sw post imem_req", imem_req, 1);

        // beq taken then not taken
        for (int t = 1; t >= 0; t--) begin
            fetch(32'h0000_0463);
            chk("beq extnr", extnr_ops, 3);
            chk("beq alusrc", alu_src_imm, 0);
            tick();
            br_taken = t[0];
            #1;
            chk("beq pc_we", pc_we, 1);
            chk("beq pc_sel", pc_sel, t);
            chk("beq retire", retire, 1);
            chk("beq rf_we", rf_we, 0);
            tick();
            br_taken = 1'b0;
            chk("beq next imem_req", imem_req, 1);
        end

        // lw x3,0(x1), zero wait: 5 cycles
        fetch(32'h0000_A183);
        chk("lw extnr", extnr_ops, 1);
        tick();
        tick();
        chk("lw dmem_req", dmem_req, 1);
        chk("lw dmem_we", dmem_we, 0);
        dmem_ready = 1'b1;
        #1;
        chk("lw mem retire", retire, 0);
        chk("lw mem pc_we", pc_we, 0);
        tick();
        dmem_ready = 1'b0;
        chk("lw wb rf_we", rf_we, 1);
        chk("lw wb wb_sel", wb_sel, 1);
        chk("lw wb pc_sel", pc_sel, 0);
        chk("lw wb retire", retire, 1);
        tick();

        // jalr x1,0(x1)
        fetch(32'h0000_80E7);
        chk("jalr extnr", extnr_ops, 1);
        tick();
        tick();
        chk("jalr rf_we", rf_we, 1);
        chk("jalr wb_sel", wb_sel, 2);
        chk("jalr pc_sel", pc_sel, 2);
        chk("jalr retire", retire, 1);
        tick();

        // add x3,x1,x2 with one fetch wait cycle
        imem_rdata = 32'h0020_81B3;
        tick();
        chk("add wait imem_req", imem_req, 1);
        chk("add wait ir", ir, 32'h0000_80E7);
        fetch(32'h0020_81B3);
        chk("add extnr", extnr_ops, 0);
        chk("add alusrc", alu_src_imm, 0);
        tick();
        tick();
        chk("add rf_we", rf_we, 1);
        chk("add wb_sel", wb_sel, 0);
        chk("add retire", retire, 1);
        tick();

        // lw aborted by reset during MEM wait
        fetch(32'h0000_A183);
        tick();
        tick();
        chk("lwrst dmem_req", dmem_req, 1);
        tick();
        rst = 1'b1;
        #1;
        chk("lwrst drop dmem_req", dmem_req, 0);
        chk("lwrst rf_we", rf_we, 0);
        chk("lwrst retire", retire, 0);
        chk("lwrst pc_we", pc_we, 0);
        dmem_ready = 1'b1;
        tick();
        chk("lwrst hold retire", retire, 0);
        chk("lwrst hold rf_we", rf_we, 0);
        dmem_ready = 1'b0;
        rst = 1'b0;
        tick();
        chk("lwrst refetch", imem_req, 1);
        chk("lwrst ir", ir, 0);
        chk("lwrst no rf_we", rf_we, 0);

        // LUI: illegal
        fetch(32'h0000_0037);
        chk("lui extnr", extnr_ops, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("lui dec retire", retire, 0);
        chk("lui dec pc_we", pc_we, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("trap flag", trap, 1);
            chk("trap imem_req", imem_req, 0);
            chk("trap retire", retire, 0);
            chk("trap pc_we", pc_we, 0);
        end
`else
        chk("lui retire", retire, 1);
        chk("lui pc_we", pc_we, 1);
        chk("lui pc_sel", pc_sel, 0);
        chk("lui rf_we", rf_we, 0);
        tick();
        chk("lui next imem_req", imem_req, 1);
        chk("lui next retire", retire, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
